// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

  // Frame sequencing states, common to TX and RX.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP_BIT  = 3'd4
  } uart_state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// UART transmit serializer: frames one word per request as
// start bit, LSB-first data, optional parity, one or two stop bits.
// Each bit lasts OVERSAMPLING pulses of the external i_tick strobe.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int OVERSAMPLING = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick,
  input  logic                  i_valid,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_parity,
  input  logic                  i_parity_odd,
  input  logic                  i_stop2,
  output logic                  o_ready,
  output logic                  o_dout,
  output logic                  o_done,
  output logic                  o_active
);

  localparam int TICK_W = cnt_width(OVERSAMPLING);
  localparam int BIT_W  = cnt_width(WORD_WIDTH + 1);
  localparam int IDX_W  = cnt_width(WORD_WIDTH);

  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(OVERSAMPLING - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(WORD_WIDTH - 1);

  uart_state_t state_q, state_d;

  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  stop2_q, stop2_d;
  logic                  dout_q, dout_d;

  logic                  bit_end;
  logic                  done_c;
  logic                  parity_bit;
  logic [BIT_W-1:0]      last_stop;

  // A bit period ends on the tick that finds the counter already at zero.
  assign bit_end    = i_tick && (tick_q == '0);
  assign parity_bit = (^data_q) ^ par_odd_q;
  assign last_stop  = stop2_q ? BIT_W'(1) : '0;

  // Next-state, counter and latch logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    done_c    = 1'b0;

    if (state_q != IDLE && i_tick) begin
      tick_d = bit_end ? TICK_MAX : tick_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d   = START_BIT;
          tick_d    = TICK_MAX;
          bit_d     = '0;
          data_d    = i_data;
          par_en_d  = i_parity;
          par_odd_d = i_parity_odd;
          stop2_d   = i_stop2;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP_BIT;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP_BIT;
          bit_d   = '0;
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          if (bit_q == last_stop) begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
            done_c  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level for the upcoming cycle, derived from the next state so the
  // registered output lines up with the state register.
  always_comb begin
    dout_d = 1'b1;
    case (state_d)
      START_BIT: dout_d = 1'b0;
      DATA:      dout_d = data_d[bit_d[IDX_W-1:0]];
      PARITY:    dout_d = parity_bit;
      default:   dout_d = 1'b1;
    endcase
  end

  // State, counters, latched frame config and the registered line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      dout_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      dout_q    <= dout_d;
    end
  end

  // o_done is flagged on the STOP_BIT->IDLE transition cycle itself so the
  // following cycle is already IDLE; a reset in that cycle suppresses it.
  assign o_done   = done_c && !i_rst;
  assign o_ready  = (state_q == IDLE);
  assign o_active = !o_ready;
  assign o_dout   = dout_q;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Scoreboard bench for uart_tx_ser: the driver pushes the expected line
// sequence of every accepted frame; the monitor logs the line level on
// every tick and checks it against the queue when o_done pulses.
module tb_uart_tx_ser;

  localparam int WW = 8;
  localparam int OS = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_tick;
  logic          i_valid;
  logic [WW-1:0] i_data;
  logic          i_parity;
  logic          i_parity_odd;
  logic          i_stop2;
  logic          o_ready;
  logic          o_dout;
  logic          o_done;
  logic          o_active;

  uart_tx_ser #(.WORD_WIDTH(WW), .OVERSAMPLING(OS)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_tick       (i_tick),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_parity     (i_parity),
    .i_parity_odd (i_parity_odd),
    .i_stop2      (i_stop2),
    .o_ready      (o_ready),
    .o_dout       (o_dout),
    .o_done       (o_done),
    .o_active     (o_active)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          nbits;
    logic [15:0] bits;
    int          cycles;
  } frame_t;

  frame_t sbq[$];
  int     vectors     = 0;
  int     miscompares = 0;
  int     tick_mode   = 1;
  int     tick_div    = 0;
  bit     mon_en      = 1'b0;

  // monitor state
  bit     in_frame = 1'b0;
  bit     chk_rdy  = 1'b0;
  int     cyc      = 0;
  int     acc_cyc  = 0;
  logic   tlog[$];
  frame_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the list of line levels of one frame, one entry per bit period.
  function automatic frame_t model(input logic [WW-1:0] d, input bit par, input bit odd,
                                   input bit s2, input bit every_cycle_tick);
    frame_t f;
    int     n;
    f.bits = '1;
    n = 0;
    f.bits[n] = 1'b0; n++;
    for (int i = 0; i < WW; i++) begin
      f.bits[n] = d[i]; n++;
    end
    if (par) begin
      f.bits[n] = (($countones(d) % 2) == 1) ^ odd; n++;
    end
    f.bits[n] = 1'b1; n++;
    if (s2) begin
      f.bits[n] = 1'b1; n++;
    end
    f.nbits  = n;
    f.cycles = every_cycle_tick ? n * OS : 0;
    return f;
  endfunction

  // Tick source: every cycle, every third cycle, or random 1-in-3.
  initial begin
    i_tick = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      case (tick_mode)
        0: i_tick = 1'b1;
        1: begin
          i_tick   = (tick_div == 0);
          tick_div = (tick_div + 1) % 3;
        end
        default: i_tick = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // Monitor: sample away from the active edge.
  initial begin
    forever begin
      @(negedge i_clk);
      cyc++;
      if (!mon_en) continue;
      if (i_rst) begin
        in_frame = 1'b0;
        chk_rdy  = 1'b0;
        tlog.delete();
        continue;
      end
      if (chk_rdy) begin
        chk("ready_after_done", o_ready, 1);
        chk_rdy = 1'b0;
      end
      chk("active_vs_ready", o_active, !o_ready);
      if (o_ready) chk("idle_line_high", o_dout, 1);
      if (in_frame && i_tick) tlog.push_back(o_dout);
      if (o_done) begin
        if (!in_frame || sbq.size() == 0) begin
          chk("done_has_expected", (in_frame && sbq.size() > 0), 1);
        end else begin
          int          nerr;
          logic [15:0] got;
          e    = sbq.pop_front();
          nerr = 0;
          got  = '1;
          chk("frame_ticks", tlog.size(), e.nbits * OS);
          for (int i = 0; i < tlog.size(); i++) begin
            if ((i / OS) >= 16) nerr++;
            else if (tlog[i] !== e.bits[i / OS]) nerr++;
          end
          for (int b = 0; b < e.nbits; b++) begin
            if (b * OS + OS / 2 < tlog.size()) got[b] = tlog[b * OS + OS / 2];
          end
          chk("frame_tick_errors", nerr, 0);
          chk("frame_bits", got, e.bits);
          if (e.cycles != 0) chk("accept_to_done_cycles", cyc - acc_cyc, e.cycles);
        end
        in_frame = 1'b0;
        chk_rdy  = 1'b1;
      end
      if (i_valid && o_ready) begin
        in_frame = 1'b1;
        acc_cyc  = cyc;
        tlog.delete();
      end
    end
  end

  task automatic tick_cycles(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 4000) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 4000) chk("wait_ready_timeout", o_ready, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || o_ready !== 1'b1) && n < 6000) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 6000) chk("wait_idle_timeout", sbq.size(), 0);
  endtask

  task automatic send(input logic [WW-1:0] d, input bit p, input bit o, input bit s2,
                      input bit expect_frame, input bit drop_valid);
    wait_ready();
    i_valid      = 1'b1;
    i_data       = d;
    i_parity     = p;
    i_parity_odd = o;
    i_stop2      = s2;
    @(posedge i_clk); #1;
    chk("accept_line_low", o_dout, 0);
    chk("accept_busy", o_ready, 0);
    if (expect_frame) sbq.push_back(model(d, p, o, s2, tick_mode == 0));
    if (drop_valid) begin
      i_valid      = 1'b0;
      i_data       = WW'($urandom);
      i_parity     = 1'($urandom);
      i_parity_odd = 1'($urandom);
      i_stop2      = 1'($urandom);
    end
  endtask

  task automatic set_mode(input int m);
    tick_mode = m;
    tick_cycles(3);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] rd;
    i_rst        = 1'b1;
    i_valid      = 1'b0;
    i_data       = '0;
    i_parity     = 1'b0;
    i_parity_odd = 1'b0;
    i_stop2      = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_dout", o_dout, 1);
    chk("rst_active", o_active, 0);
    chk("rst_done", o_done, 0);
    i_rst  = 1'b0;
    mon_en = 1'b1;
    tick_cycles(2);

    // Directed frames.
    set_mode(1);
    send(8'h55, 0, 0, 0, 1, 1); wait_idle();
    send(8'hA7, 1, 0, 0, 1, 1); wait_idle();
    send(8'hA7, 1, 1, 0, 1, 1); wait_idle();
    send(8'h00, 0, 0, 1, 1, 1); wait_idle();

    // Valid held across frames, data changed mid-frame.
    send(8'h3A, 0, 0, 0, 1, 0);
    tick_cycles(100);
    i_data = 8'hFF;
    send(8'hFF, 0, 0, 0, 1, 1);
    wait_idle();

    // Reset during data bit 3 with a tick every cycle.
    set_mode(0);
    rd = 8'hF7;
    send(rd, 0, 0, 0, 0, 1);
    tick_cycles(70);
    chk("pre_reset_bit3", o_dout, rd[3]);
    i_rst = 1'b1;
    tick_cycles(1);
    i_rst = 1'b0;
    chk("post_reset_dout", o_dout, 1);
    chk("post_reset_ready", o_ready, 1);
    chk("post_reset_active", o_active, 0);
    tick_cycles(300);

    // Tick every cycle: frame length in cycles.
    send(8'h3C, 0, 0, 0, 1, 1); wait_idle();
    send(8'hA7, 1, 0, 1, 1, 1); wait_idle();

    // Randomized frames under random tick patterns.
    for (int k = 0; k < 16; k++) begin
      set_mode($urandom_range(0, 2));
      send(WW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1, 1);
      wait_idle();
    end

    tick_cycles(5);
    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
